pss_ref_reader: RTL and testbench
=================================

# pss_ref_reader

Read-side sequencer for the PSS reference ROM in the sync IP. On a start request it sweeps ROM addresses 0..pDAT_Num-1, absorbs the ROM's one-cycle registered read latency, and presents the reference words downstream as a valid/ready stream with a last-word flag. It sits between the PSS ROM and the PSS correlator and supports single-shot and continuous looping sweeps.

## Interface
- pDAT_W, 72, ROM word width
- pDAT_Num, 1024, ROM depth in words (≥2)
- pADDR_W, 11, ROM address width; 2^pADDR_W ≥ pDAT_Num
- iclk  in  1  clock; all logic on posedge
- irst  in  1  reset, synchronous, active-high
- istart  in  1  start request; honoured only in IDLE
- iloop  in  1  loop mode, sampled with accepted istart
- istop  in  1  in loop mode: end at the next sweep boundary
- oaddr  out  pADDR_W  ROM address
- oren  out  1  ROM read enable (ROM `ival`)
- irom_dat  in  pDAT_W  ROM data, valid the cycle after oren
- odat  out  pDAT_W  stream data
- oval  out  1  stream valid
- olast  out  1  marks word pDAT_Num-1 of each sweep
- irdy  in  1  downstream ready
- obusy  out  1  high from accepted start until done
- odone  out  1  one-cycle pulse at end of session

## Operation
- FSM: IDLE, RUN, DRAIN.
- IDLE: istart=1 → RUN; latch iloop into loop_q; address counter = 0.
- RUN: issue reads (oren=1, oaddr=counter) when credit allows; counter increments per issue; at pDAT_Num-1 wraps to 0.
  - Issuing address pDAT_Num-1 with loop_q=0 → DRAIN.
  - loop_q=1: stop_q sets on istop=1 (sticky); issuing address pDAT_Num-1 with stop_q=1 → DRAIN; else continue at 0.
- DRAIN: no reads; when FIFO empty and no read in flight → IDLE with odone=1 for one cycle.
- Output buffer: 2-entry FIFO of {data, last}; written the cycle after each oren from irom_dat; last = (address issued == pDAT_Num-1).
- oval = FIFO non-empty; odat/olast = FIFO head; pop on oval & irdy.
- Credit rule: issue iff occupancy + inflight − pop ≤ 1 (inflight = oren of previous cycle). FIFO never overflows; no data lost under any irdy pattern.
- odat/olast hold stable while oval=1 and irdy=0.
- istart outside IDLE ignored; istop ignored when loop_q=0 or outside RUN.
- obusy = state ≠ IDLE.
- irst any time: state IDLE, FIFO flushed, in-flight read discarded, counters, loop_q, stop_q cleared.

## Timing
- Reset values: oaddr=0, oren=0, odat=0, oval=0, olast=0, obusy=0, odone=0.
- istart high in cycle 0 → cycle 1: obusy=1, oren=1, oaddr=0 → cycle 2: irom_dat valid → cycle 3: oval=1, odat=rom[0].
- irdy held high: one word per cycle, gapless; single sweep of N words: oval cycles 3..N+2, olast cycle N+2, odone cycle N+3, obusy low cycle N+4.
- Loop mode with irdy high: rom[N-1] immediately followed by rom[0], no bubble.
- irdy low: at most 2 issued reads outstanding; issue resumes the cycle pop occurs.

## Configuration
- PSS_READER_CNT_EN defined: adds output `osweep_cnt` [15:0], counts words accepted with olast=1, saturates at 0xFFFF, cleared by irst and by accepted istart.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Single sweep, pDAT_Num=1024, irdy=1: istart pulse → 1024 words rom[0..1023] in cycles 3..1026, olast only on 1023, odone at cycle 1027.
- Backpressure: random irdy (50%) → same 1024-word sequence in order, no drops/duplicates, odat stable while stalled, oren never with occupancy+inflight=2 and no pop.
- Loop: iloop=1, istop asserted mid sweep 3 → exactly 3 sweeps (3072 words, 3 olast), then odone; no bubble at wrap with irdy=1.
- istart while busy at cycle 100 → ignored, output identical to single sweep.
- irst at cycle 500 of sweep → next cycle all outputs at reset values; new istart restarts from rom[0].
- PSS_READER_CNT_EN: two single sweeps → osweep_cnt=1 after first, reset to 0 on second istart, 1 at end.

Source files
------------

// File: rtl/pss_ref_reader.sv
// Read-side sequencer for the PSS reference ROM: sweeps the ROM, absorbs its read latency and
// streams the words out as valid/ready with a last flag. Optional sweep counter: PSS_READER_CNT_EN.
module pss_ref_reader #(
    parameter int unsigned pDAT_W   = 72,
    parameter int unsigned pDAT_Num = 1024,
    parameter int unsigned pADDR_W  = 11
) (
    input  logic               iclk,
    input  logic               irst,
    input  logic               istart,
    input  logic               iloop,
    input  logic               istop,
    output logic [pADDR_W-1:0] oaddr,
    output logic               oren,
    input  logic [pDAT_W-1:0]  irom_dat,
    output logic [pDAT_W-1:0]  odat,
    output logic               oval,
    output logic               olast,
    input  logic               irdy,
    output logic               obusy,
`ifdef PSS_READER_CNT_EN
    output logic [15:0]        osweep_cnt,
`endif
    output logic               odone
);

    localparam logic [pADDR_W-1:0] lpLAST_ADDR = pADDR_W'(pDAT_Num - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e             state_q;
    logic [pADDR_W-1:0] addr_q;
    logic               loop_q;
    logic               stop_q;
    logic               inflight_q;
    logic               inflight_last_q;
    logic [pDAT_W-1:0]  fifo_dat_q [2];
    logic [1:0]         fifo_last_q;
    logic               wptr_q;
    logic               rptr_q;
    logic [1:0]         cnt_q;

    logic               pop;
    logic               issue;
    logic               at_last;
    logic [2:0]         credit;

    assign at_last = (addr_q == lpLAST_ADDR);
    assign pop     = oval & irdy;
    // Words already buffered or on their way, after this cycle's pop; a new read needs a free slot.
    assign credit  = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
    assign issue   = (state_q == StRun) && (credit <= 3'd1);

    assign oren  = issue;
    assign oaddr = addr_q;
    assign oval  = (cnt_q != 2'd0);
    assign odat  = fifo_dat_q[rptr_q];
    assign olast = fifo_last_q[rptr_q] & oval;
    assign obusy = (state_q != StIdle);
    assign odone = (state_q == StDrain) && (cnt_q == 2'd0) && !inflight_q;

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            loop_q          <= 1'b0;
            stop_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_dat_q[i] <= '0;
            end
            fifo_last_q     <= '0;
            wptr_q          <= 1'b0;
            rptr_q          <= 1'b0;
            cnt_q           <= '0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue && at_last;

            if (inflight_q) begin
                fifo_dat_q[wptr_q]  <= irom_dat;
                fifo_last_q[wptr_q] <= inflight_last_q;
                wptr_q              <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            cnt_q <= cnt_q + 2'(inflight_q) - 2'(pop);

            case (state_q)
                StIdle: begin
                    if (istart) begin
                        state_q <= StRun;
                        loop_q  <= iloop;
                        stop_q  <= 1'b0;
                        addr_q  <= '0;
                    end
                end
                StRun: begin
                    if (loop_q && istop) begin
                        stop_q <= 1'b1;
                    end
                    if (issue) begin
                        addr_q <= at_last ? '0 : addr_q + 1'b1;
                        if (at_last && (!loop_q || stop_q)) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (odone) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef PSS_READER_CNT_EN
    logic [15:0] sweep_cnt_q;

    always_ff @(posedge iclk) begin
        if (irst || ((state_q == StIdle) && istart)) begin
            sweep_cnt_q <= '0;
        end else if (pop && olast && (sweep_cnt_q != 16'hFFFF)) begin
            sweep_cnt_q <= sweep_cnt_q + 16'd1;
        end
    end

    assign osweep_cnt = sweep_cnt_q;
`endif

endmodule

// File: tb/tb_pss_ref_reader.sv
// Randomized self-checking bench for pss_ref_reader: expected stream built from the ROM image,
// plus cycle timing, stall stability and outstanding-read checks.
module tb_pss_ref_reader;

    localparam int unsigned N  = 1024;
    localparam int unsigned DW = 72;
    localparam int unsigned AW = 11;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          last;
    } word_t;

    logic          clk = 1'b0;
    logic          irst = 1'b1;
    logic          istart = 1'b0;
    logic          iloop = 1'b0;
    logic          istop = 1'b0;
    logic [AW-1:0] oaddr;
    logic          oren;
    logic [DW-1:0] irom_dat = '0;
    logic [DW-1:0] odat;
    logic          oval;
    logic          olast;
    logic          irdy = 1'b1;
    logic          obusy;
    logic          odone;
`ifdef PSS_READER_CNT_EN
    logic [15:0]   osweep_cnt;
`endif

    pss_ref_reader #(
        .pDAT_W   (DW),
        .pDAT_Num (N),
        .pADDR_W  (AW)
    ) dut (
        .iclk     (clk),
        .irst     (irst),
        .istart   (istart),
        .iloop    (iloop),
        .istop    (istop),
        .oaddr    (oaddr),
        .oren     (oren),
        .irom_dat (irom_dat),
        .odat     (odat),
        .oval     (oval),
        .olast    (olast),
        .irdy     (irdy),
        .obusy    (obusy),
`ifdef PSS_READER_CNT_EN
        .osweep_cnt (osweep_cnt),
`endif
        .odone    (odone)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] rom [N];
    always @(posedge clk) begin
        if (oren) irom_dat <= rom[oaddr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    word_t         exp_q [$];
    bit            mon_en = 1'b0;
    bit            rdy_rand = 1'b0;
    int            t0 = 0;
    int            first_val, last_rel, done_rel, busy_low, n_done, n_last, n_pop;
    int            outstanding = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_dat;
    logic          prev_last;

    // Downstream ready pattern, changed just after each active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1 irdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            int    rel;
            int    pop_i;
            word_t e;
            rel   = cyc - t0;
            pop_i = int'(oval && irdy);
            if (oren) begin
                check_eq("credit", DW'((outstanding - pop_i) <= 1), DW'(1));
            end
            if (prev_stall) begin
                check_eq("stall_val", DW'(oval), DW'(1));
                check_eq("stall_dat", odat, prev_dat);
                check_eq("stall_last", DW'(olast), DW'(prev_last));
            end
            if (pop_i != 0) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_word", DW'(1), DW'(0));
                end else begin
                    e = exp_q.pop_front();
                    check_eq("odat", odat, e.dat);
                    check_eq("olast", DW'(olast), DW'(e.last));
                end
                if (first_val < 0) first_val = rel;
                if (olast) begin
                    last_rel = rel;
                    n_last++;
                end
                n_pop++;
            end
            if (odone) begin
                n_done++;
                if (done_rel < 0) done_rel = rel;
            end
            if (!obusy && busy_low < 0 && first_val >= 0) busy_low = rel;
            prev_stall  = oval && !irdy;
            prev_dat    = odat;
            prev_last   = olast;
            outstanding = outstanding + int'(oren) - pop_i;
        end
    end

    task automatic push_sweeps(input int sweeps);
        for (int s = 0; s < sweeps; s++) begin
            for (int i = 0; i < N; i++) begin
                exp_q.push_back('{dat: rom[i], last: (i == N - 1)});
            end
        end
    endtask

    // Pulses istart for one cycle; that cycle is cycle 0 of the session.
    task automatic start(input logic loop);
        @(posedge clk);
        #1;
        istart    = 1'b1;
        iloop     = loop;
        t0        = cyc;
        first_val = -1;
        last_rel  = -1;
        done_rel  = -1;
        busy_low  = -1;
        n_done    = 0;
        n_last    = 0;
        n_pop     = 0;
        @(posedge clk);
        #1;
        istart = 1'b0;
        iloop  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_rel < 0; i++) begin
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_rel(input int rel);
        while (cyc - t0 < rel) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge clk);
        check_eq({tag, "_oaddr"}, DW'(oaddr), DW'(0));
        check_eq({tag, "_oren"}, DW'(oren), DW'(0));
        check_eq({tag, "_odat"}, odat, DW'(0));
        check_eq({tag, "_oval"}, DW'(oval), DW'(0));
        check_eq({tag, "_olast"}, DW'(olast), DW'(0));
        check_eq({tag, "_obusy"}, DW'(obusy), DW'(0));
        check_eq({tag, "_odone"}, DW'(odone), DW'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stop_at;
        for (int i = 0; i < N; i++) begin
            rom[i] = {8'($urandom), $urandom, $urandom};
        end
        irst = 1'b1;
        repeat (3) @(posedge clk);
        #1 irst = 1'b0;
        check_reset_vals("rst");
        mon_en = 1'b1;

        // Single sweep, full throughput, with an ignored istart at cycle 100.
        push_sweeps(1);
        start(1'b0);
        @(negedge clk);
        check_eq("c1_obusy", DW'(obusy), DW'(1));
        check_eq("c1_oren", DW'(oren), DW'(1));
        check_eq("c1_oaddr", DW'(oaddr), DW'(0));
        wait_rel(100);
        istart = 1'b1;
        iloop  = 1'b1;
        @(posedge clk);
        #1;
        istart = 1'b0;
        iloop  = 1'b0;
        wait_done(4 * N);
        check_eq("s_first_val", DW'(first_val), DW'(3));
        check_eq("s_last_cyc", DW'(last_rel), DW'(N + 2));
        check_eq("s_done_cyc", DW'(done_rel), DW'(N + 3));
        check_eq("s_busy_low", DW'(busy_low), DW'(N + 4));
        check_eq("s_n_done", DW'(n_done), DW'(1));
        check_eq("s_n_last", DW'(n_last), DW'(1));
        check_eq("s_left", DW'(exp_q.size()), DW'(0));
`ifdef PSS_READER_CNT_EN
        check_eq("cnt_first", DW'(osweep_cnt), DW'(1));
`endif

        // Random backpressure.
        rdy_rand = 1'b1;
        push_sweeps(1);
        start(1'b0);
`ifdef PSS_READER_CNT_EN
        @(negedge clk);
        check_eq("cnt_cleared", DW'(osweep_cnt), DW'(0));
`endif
        wait_done(8 * N);
        check_eq("bp_n_done", DW'(n_done), DW'(1));
        check_eq("bp_n_pop", DW'(n_pop), DW'(N));
        check_eq("bp_left", DW'(exp_q.size()), DW'(0));
`ifdef PSS_READER_CNT_EN
        check_eq("cnt_second", DW'(osweep_cnt), DW'(1));
`endif
        rdy_rand = 1'b0;
        repeat (2) @(posedge clk);

        // Loop mode, stop requested somewhere inside the third sweep.
        push_sweeps(3);
        stop_at = $urandom_range(2 * N + 8, 3 * N - 16);
        start(1'b1);
        for (int i = 0; i < 8 * N && n_pop < stop_at; i++) begin
            @(posedge clk);
            #1;
        end
        istop = 1'b1;
        @(posedge clk);
        #1 istop = 1'b0;
        wait_done(8 * N);
        check_eq("lp_n_pop", DW'(n_pop), DW'(3 * N));
        check_eq("lp_n_last", DW'(n_last), DW'(3));
        check_eq("lp_n_done", DW'(n_done), DW'(1));
        check_eq("lp_gapless", DW'(last_rel - first_val + 1), DW'(3 * N));
        check_eq("lp_left", DW'(exp_q.size()), DW'(0));

        // Reset in the middle of a sweep, then a clean restart.
        push_sweeps(1);
        start(1'b0);
        wait_rel(500);
        mon_en = 1'b0;
        irst   = 1'b1;
        @(posedge clk);
        #1 irst = 1'b0;
        check_reset_vals("midrst");
        exp_q.delete();
        outstanding = 0;
        prev_stall  = 1'b0;
        mon_en      = 1'b1;
        push_sweeps(1);
        start(1'b0);
        wait_done(4 * N);
        check_eq("rs_first_val", DW'(first_val), DW'(3));
        check_eq("rs_n_pop", DW'(n_pop), DW'(N));
        check_eq("rs_done_cyc", DW'(done_rel), DW'(N + 3));
        check_eq("rs_left", DW'(exp_q.size()), DW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
